tetris_input_ctrl: RTL

Upstream stage of the game-logic block. Converts the raw USB keycode into discrete, rate-limited game actions, one action per frame at most. Left/right use delayed auto-shift (DAS) and an auto-repeat rate (ARR). Soft drop repeats at a fixed rate; rotate and hard drop fire once per press. Actions reach the game logic over a valid/ready handshake in the frame_clk domain.

---
 rtl/tetris_input_ctrl_pkg.sv | 23 ++
 rtl/tetris_input_ctrl_if.sv | 12 +
 rtl/tetris_input_ctrl_repeat_timer.sv | 41 ++++
 rtl/tetris_input_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/tetris_input_ctrl_pkg.sv
// Shared types and default keycodes for the keyboard-to-game-action front end.
package tetris_input_pkg;

  typedef enum logic [2:0] {
    ACT_NONE  = 3'd0,
    ACT_LEFT  = 3'd1,
    ACT_RIGHT = 3'd2,
    ACT_DOWN  = 3'd3,
    ACT_ROT   = 3'd4,
    ACT_DROP  = 3'd5
  } action_t;

  typedef enum logic [2:0] {S_IDLE, S_DAS, S_ARR, S_SOFT, S_HELD} state_t;

  typedef enum logic [1:0] {SEL_DAS, SEL_ARR, SEL_SOFT} period_sel_t;

  localparam logic [7:0] DEF_KEY_LEFT  = 8'h04;
  localparam logic [7:0] DEF_KEY_RIGHT = 8'h07;
  localparam logic [7:0] DEF_KEY_DOWN  = 8'h16;
  localparam logic [7:0] DEF_KEY_ROT   = 8'h1A;
  localparam logic [7:0] DEF_KEY_DROP  = 8'h2C;

endpackage

// File: rtl/tetris_input_ctrl_if.sv
// Valid/ready action channel from the input controller to the game logic.
interface tetris_input_ctrl_if;
  import tetris_input_pkg::*;

  logic    action_valid;
  action_t action;
  logic    action_ready;

  modport master (output action_valid, output action, input action_ready);
  modport slave  (input action_valid, input action, output action_ready);

endinterface

// File: rtl/tetris_input_ctrl_repeat_timer.sv
// Frame counter with a selectable terminal count; o_tc pulses on the frame that
// reaches period-1 and the count wraps to zero on that same edge.
module tetris_repeat_timer
  import tetris_input_pkg::*;
#(
  parameter int unsigned DAS_DELAY   = 10,
  parameter int unsigned ARR_PERIOD  = 2,
  parameter int unsigned SOFT_PERIOD = 3
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        i_clear,
  input  logic        i_en,
  input  period_sel_t i_sel,
  output logic        o_tc
);

  logic [7:0] r_count;
  logic [7:0] w_last;

  always_comb begin
    case (i_sel)
      SEL_DAS: w_last = 8'(DAS_DELAY - 1);
      SEL_ARR: w_last = 8'(ARR_PERIOD - 1);
      default: w_last = 8'(SOFT_PERIOD - 1);
    endcase
  end

  assign o_tc = i_en && (r_count == w_last);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else if (i_clear || o_tc) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 8'd1;
    end
  end

endmodule

// File: rtl/tetris_input_ctrl.sv
// Keycode to rate-limited game actions (DAS/ARR for left/right, fixed-rate soft drop).
// Define TETRIS_INPUT_DAS_EN for auto-repeat on left/right; otherwise one move per press.
module tetris_input_ctrl
  import tetris_input_pkg::*;
#(
  parameter logic [7:0]  KEY_LEFT    = DEF_KEY_LEFT,
  parameter logic [7:0]  KEY_RIGHT   = DEF_KEY_RIGHT,
  parameter logic [7:0]  KEY_DOWN    = DEF_KEY_DOWN,
  parameter logic [7:0]  KEY_ROT     = DEF_KEY_ROT,
  parameter logic [7:0]  KEY_DROP    = DEF_KEY_DROP,
  parameter int unsigned DAS_DELAY   = 10,
  parameter int unsigned ARR_PERIOD  = 2,
  parameter int unsigned SOFT_PERIOD = 3
) (
  input  logic                       frame_clk,
  input  logic                       Reset,
  input  logic [7:0]                 keycode,
  input  logic                       enable,
  tetris_input_ctrl_if.master        act_if,
  output logic                       repeating
);

  state_t      r_state;
  logic        r_valid;
  action_t     r_action;
  logic [7:0]  r_key_q;

  action_t     w_class;
  logic        w_press;
  logic        w_timing;
  logic        w_tc;
  logic        w_issue;
  logic        w_load;
  period_sel_t w_sel;
  state_t      w_next;

  function automatic state_t press_state(input action_t c);
    state_t s;
    case (c)
      ACT_LEFT, ACT_RIGHT: begin
`ifdef TETRIS_INPUT_DAS_EN
        s = S_DAS;
`else
        s = S_HELD;
`endif
      end
      ACT_DOWN: s = S_SOFT;
      default:  s = S_HELD;
    endcase
    return s;
  endfunction

  always_comb begin
    w_class = ACT_NONE;
    if (keycode != 8'h00) begin
      if      (keycode == KEY_LEFT)  w_class = ACT_LEFT;
      else if (keycode == KEY_RIGHT) w_class = ACT_RIGHT;
      else if (keycode == KEY_DOWN)  w_class = ACT_DOWN;
      else if (keycode == KEY_ROT)   w_class = ACT_ROT;
      else if (keycode == KEY_DROP)  w_class = ACT_DROP;
    end

    w_press  = (w_class != ACT_NONE) && (keycode != r_key_q);
    // Timer only runs while the same key stays held in a repeating state.
    w_timing = enable && (w_class != ACT_NONE) && !w_press &&
               ((r_state == S_DAS) || (r_state == S_ARR) || (r_state == S_SOFT));

    w_sel = SEL_SOFT;
    if (r_state == S_DAS)      w_sel = SEL_DAS;
    else if (r_state == S_ARR) w_sel = SEL_ARR;

    w_next = r_state;
    if (!enable || (w_class == ACT_NONE)) w_next = S_IDLE;
    else if (w_press)                     w_next = press_state(w_class);
    else if (r_state == S_IDLE)           w_next = S_HELD;
    else if ((r_state == S_DAS) && w_tc)  w_next = S_ARR;

    w_issue = enable && (w_press || w_tc);
    // A repeat never overwrites an unaccepted action; a fresh press always does.
    w_load  = w_issue && (w_press || !(r_valid && !act_if.action_ready));
  end

  tetris_repeat_timer #(
    .DAS_DELAY   (DAS_DELAY),
    .ARR_PERIOD  (ARR_PERIOD),
    .SOFT_PERIOD (SOFT_PERIOD)
  ) u_timer (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .i_clear   (!w_timing),
    .i_en      (w_timing),
    .i_sel     (w_sel),
    .o_tc      (w_tc)
  );

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_valid  <= 1'b0;
      r_action <= ACT_NONE;
      r_key_q  <= 8'h00;
    end else begin
      r_key_q <= keycode;
      r_state <= w_next;
      if (!enable) begin
        r_valid  <= 1'b0;
        r_action <= ACT_NONE;
      end else if (w_load) begin
        r_valid  <= 1'b1;
        r_action <= w_class;
      end else if (act_if.action_ready) begin
        r_valid  <= 1'b0;
        r_action <= ACT_NONE;
      end
    end
  end

  assign act_if.action_valid = r_valid;
  assign act_if.action       = r_action;

`ifdef TETRIS_INPUT_DAS_EN
  assign repeating = (r_state == S_ARR);
`else
  assign repeating = 1'b0;
`endif

endmodule
